// File: rtl/train_pkg.sv
// Shared constants for the train controller: sensor indices and motor direction codes.
package train_pkg;

  localparam int unsigned NUM_SENSORS = 5;

  localparam int unsigned SENS_A_ENTRY = 0;
  localparam int unsigned SENS_B_ENTRY = 1;
  localparam int unsigned SENS_B_EXIT  = 2;
  localparam int unsigned SENS_A_EXIT  = 3;
  localparam int unsigned SENS_SPARE   = 4;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;

endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: synchroniser, debounce, rising-edge strobe and stuck-active detection.
module sensor_debounce_ch #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned STUCK_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  input  logic clr_fault,
  output logic stable,
  output logic rise,
  output logic stuck,
  output logic stuck_next
);

  localparam int unsigned DebW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DebW-1:0]        deb_cnt_q, deb_cnt_d;
  logic [StuckW-1:0]      stuck_cnt_q, stuck_cnt_d;
  logic                   stable_d;
  logic                   rise_d;
  logic                   stuck_d;

  assign sync       = sync_q[SYNC_STAGES-1];
  assign stuck_next = stuck_d;

  always_comb begin
    deb_cnt_d = '0;
    stable_d  = stable;
    if (sync != stable) begin
      // The count that would reach DEB_CYCLES flips the level instead of being stored.
      if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
        stable_d = sync;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
    rise_d = stable_d & ~stable;
  end

  always_comb begin
    stuck_cnt_d = '0;
    if (stable) begin
      if (stuck_cnt_q == StuckW'(STUCK_CYCLES)) begin
        stuck_cnt_d = stuck_cnt_q;
      end else begin
        stuck_cnt_d = stuck_cnt_q + StuckW'(1);
      end
    end
    // Reaching or sitting at threshold overrides a clear request.
    stuck_d = (stuck & ~clr_fault) | (stuck_cnt_d == StuckW'(STUCK_CYCLES));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q      <= '0;
      deb_cnt_q   <= '0;
      stable      <= 1'b0;
      rise        <= 1'b0;
      stuck_cnt_q <= '0;
      stuck       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
      deb_cnt_q   <= deb_cnt_d;
      stable      <= stable_d;
      rise        <= rise_d;
      stuck_cnt_q <= stuck_cnt_d;
      stuck       <= stuck_d;
    end
  end

endmodule

// File: rtl/train_sensor_conditioner.sv
// Conditions the five raw track sensors into clean levels, rise strobes and stuck faults.
module train_sensor_conditioner
  import train_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned STUCK_CYCLES = 1000000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_SENSORS-1:0] RAW_S,
  input  logic                   CLR_FAULT,
  output logic                   S1,
  output logic                   S2,
  output logic                   S3,
  output logic                   S4,
  output logic                   S5,
  output logic [NUM_SENSORS-1:0] RISE,
  output logic [NUM_SENSORS-1:0] STUCK,
  output logic                   FAULT
);

  logic [NUM_SENSORS-1:0] stable;
  logic [NUM_SENSORS-1:0] rise;
  logic [NUM_SENSORS-1:0] stuck;
  logic [NUM_SENSORS-1:0] stuck_next;
  logic                   fault_q;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    sensor_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ch (
      .CLK       (CLK),
      .RESET     (RESET),
      .raw       (RAW_S[i]),
      .clr_fault (CLR_FAULT),
      .stable    (stable[i]),
      .rise      (rise[i]),
      .stuck     (stuck[i]),
      .stuck_next(stuck_next[i])
    );
  end

  // Built from next-state bits so FAULT moves on the same edge as STUCK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= |stuck_next;
    end
  end

  assign S1    = stable[SENS_A_ENTRY];
  assign S2    = stable[SENS_B_ENTRY];
  assign S3    = stable[SENS_B_EXIT];
  assign S4    = stable[SENS_A_EXIT];
  assign S5    = stable[SENS_SPARE];
  assign RISE  = rise;
  assign STUCK = stuck;
  assign FAULT = fault_q;

endmodule

// File: tb/tb_train_sensor_conditioner.sv
// Directed plan plus randomized stimulus against a sliding-window reference model.
module tb_train_sensor_conditioner;

  localparam int unsigned Sync  = 2;
  localparam int unsigned Deb   = 4;
  localparam int unsigned Stuck = 20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [4:0] RAW_S = '0;
  logic       CLR_FAULT = 1'b0;
  logic       S1, S2, S3, S4, S5;
  logic [4:0] RISE, STUCK;
  logic       FAULT;
  logic [4:0] s_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel raw history, window of recent synced samples, run length of S=1.
  logic [Sync-1:0] m_sync[5];
  logic [Deb-1:0]  m_win[5];
  logic            m_stable[5];
  logic            m_rise[5];
  logic            m_stuck[5];
  int              m_run[5];

  train_sensor_conditioner #(
    .SYNC_STAGES (Sync),
    .DEB_CYCLES  (Deb),
    .STUCK_CYCLES(Stuck)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RAW_S    (RAW_S),
    .CLR_FAULT(CLR_FAULT),
    .S1       (S1),
    .S2       (S2),
    .S3       (S3),
    .S4       (S4),
    .S5       (S5),
    .RISE     (RISE),
    .STUCK    (STUCK),
    .FAULT    (FAULT)
  );

  always #5 CLK = ~CLK;
  assign s_vec = {S5, S4, S3, S2, S1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      m_sync[c] = '0; m_win[c] = '0; m_stable[c] = 1'b0;
      m_rise[c] = 1'b0; m_stuck[c] = 1'b0; m_run[c] = 0;
    end
  endtask

  task automatic model_step(input logic [4:0] raw, input logic clr);
    logic s, ns;
    for (int c = 0; c < 5; c++) begin
      s = m_sync[c][Sync-1];
      m_win[c] = {m_win[c][Deb-2:0], s};
      // Level flips once the last Deb synced samples all disagree with it.
      ns = (m_win[c] == {Deb{~m_stable[c]}}) ? ~m_stable[c] : m_stable[c];
      m_rise[c] = ns & ~m_stable[c];
      m_run[c] = m_stable[c] ? m_run[c] + 1 : 0;
      m_stuck[c] = (m_stuck[c] & ~clr) | (m_run[c] >= Stuck);
      m_stable[c] = ns;
      m_sync[c] = {m_sync[c][Sync-2:0], raw[c]};
    end
  endtask

  task automatic compare_all();
    logic [4:0] es, er, ek;
    for (int c = 0; c < 5; c++) begin
      es[c] = m_stable[c]; er[c] = m_rise[c]; ek[c] = m_stuck[c];
    end
    check_eq("S", 32'(s_vec), 32'(es));
    check_eq("RISE", 32'(RISE), 32'(er));
    check_eq("STUCK", 32'(STUCK), 32'(ek));
    check_eq("FAULT", 32'(FAULT), 32'(|ek));
  endtask

  task automatic step(input logic [4:0] raw, input logic clr);
    RAW_S = raw;
    CLR_FAULT = clr;
    @(posedge CLK);
    if (!RESET) model_step(raw, clr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    step(RAW_S, 1'b0);
    step(RAW_S, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    step(5'b0, 1'b0);
    RESET = 1'b0;

    // 1: single channel latency and one-cycle strobe
    for (int i = 1; i <= 8; i++) begin
      step(5'b00001, 1'b0);
      if (i == 5) check_eq("t1_s_before", 32'(s_vec), 32'h0);
      if (i == 6) begin
        check_eq("t1_s_at6", 32'(s_vec), 32'h01);
        check_eq("t1_rise_at6", 32'(RISE), 32'h01);
      end
      if (i == 7) check_eq("t1_rise_once", 32'(RISE), 32'h0);
    end
    for (int i = 0; i < 8; i++) step(5'b0, 1'b0);

    // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
    for (int i = 0; i < 3; i++) step(5'b00010, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(5'b0, 1'b0);
      check_eq("t2_glitch_s", 32'(s_vec), 32'h0);
    end
    for (int i = 1; i <= 4; i++) step(5'b00010, 1'b0);
    for (int i = 5; i <= 12; i++) begin
      step(5'b0, 1'b0);
      if (i == 6) check_eq("t2_pulse_high", 32'(s_vec), 32'h02);
      if (i == 10) check_eq("t2_pulse_low", 32'(s_vec), 32'h0);
    end

    // 3: stuck after threshold, cleared once the sensor has dropped
    for (int i = 1; i <= 30; i++) begin
      step(5'b00100, 1'b0);
      if (i == 25) check_eq("t3_stuck_before", 32'(STUCK), 32'h0);
      if (i == 26) begin
        check_eq("t3_stuck_at26", 32'(STUCK), 32'h04);
        check_eq("t3_fault_at26", 32'(FAULT), 32'h1);
      end
    end
    for (int i = 0; i < 8; i++) step(5'b0, 1'b0);
    check_eq("t3_stuck_held", 32'(STUCK), 32'h04);
    step(5'b0, 1'b1);
    check_eq("t3_stuck_clr", 32'(STUCK), 32'h0);
    check_eq("t3_fault_clr", 32'(FAULT), 32'h0);

    // 4: clear held during threshold, set wins
    for (int i = 0; i < 35; i++) step(5'b01000, 1'b1);
    check_eq("t4_set_wins", 32'(STUCK), 32'h08);
    for (int i = 0; i < 8; i++) step(5'b0, 1'b1);
    check_eq("t4_cleared", 32'(STUCK), 32'h0);

    // 5: reset mid-debounce discards progress
    for (int i = 0; i < 10; i++) step(5'b01111, 1'b0);
    for (int i = 0; i < 3; i++) step(5'b11111, 1'b0);
    RESET = 1'b1;
    #1;
    check_eq("t5_async_s", 32'(s_vec), 32'h0);
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(5'b10000, 1'b0);
      if (i == 5) check_eq("t5_s5_before", 32'(S5), 32'h0);
      if (i == 6) check_eq("t5_s5_at6", 32'(S5), 32'h1);
    end
    for (int i = 0; i < 8; i++) step(5'b0, 1'b0);

    // 6: all channels toggling every cycle never settle
    for (int i = 0; i < 50; i++) begin
      step((i % 2 == 0) ? 5'b11111 : 5'b00000, 1'b0);
      check_eq("t6_s", 32'(s_vec), 32'h0);
      check_eq("t6_rise", 32'(RISE), 32'h0);
    end

    // Randomized holds, glitches, clears and occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      logic [4:0] r;
      int len;
      r = 5'($urandom);
      len = ($urandom_range(0, 9) == 0) ? 28 : $urandom_range(1, 8);
      if ($urandom_range(0, 59) == 0) do_reset();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0) r[$urandom_range(0, 4)] ^= 1'b1;
        step(r, $urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/train_sensor_conditioner.md
Name: train_sensor_conditioner

Overview:
Front-end stage between the raw track reed/IR sensors and the train-controller FSM. The FSM consumes its S1..S5 inputs directly.
- Synchronises each asynchronous raw sensor to CLK and debounces it, so the FSM only sees clean levels.
- Emits a one-cycle rising-edge strobe per sensor for logging and counters.
- Flags any sensor held active abnormally long (stuck or blocked sensor) as a sticky fault.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel (legal range 2..4).
DEB_CYCLES, 16, consecutive cycles a synchronised value must differ from the current stable value before the stable value flips (legal range 2..65535).
STUCK_CYCLES, 1000000, consecutive cycles of stable=1 after which the channel's STUCK bit sets (must exceed DEB_CYCLES).

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
RAW_S  in  5  raw sensor inputs, asynchronous to CLK; bit0=sensor1 .. bit4=sensor5; 1=train present
CLR_FAULT  in  1  synchronous clear of all STUCK bits
S1, S2, S3, S4, S5  out  1 each  debounced stable levels; connect directly to the FSM
RISE  out  5  one-cycle strobe on each stable 0->1 transition
STUCK  out  5  sticky per-channel stuck-active flags
FAULT  out  1  OR of STUCK

Behaviour:
- All 5 channels are identical and independent; there is no cross-channel interaction except the FAULT OR-reduction.
- Reset (asynchronous assert, all flops):
  - sync chain = 0, stable = 0, debounce counter = 0, stuck counter = 0.
  - S1..S5 = 0, RISE = 0, STUCK = 0, FAULT = 0.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel. Its last stage is "sync".
- Debounce, every cycle:
  - If sync == stable, the debounce counter clears to 0.
  - Else the counter increments. On the edge where the incremented count would reach DEB_CYCLES, stable <= sync and the counter clears.
  - The counter width is ceil(log2(DEB_CYCLES+1)). It never wraps.
- Latency: a raw level held steady changes S after exactly SYNC_STAGES + DEB_CYCLES rising CLK edges.
- Glitches: any raw pulse or gap shorter than DEB_CYCLES cycles (after sync) produces no change on S.
- Symmetric: 1->0 transitions use the same rule as 0->1.
- S outputs are the stable registers themselves. There is no combinational path from RAW_S.
- RISE: registered. It is high exactly in the first cycle in which stable is 1 after being 0, so it is coincident with S going high. There is no strobe on falling transitions.
- Stuck detection:
  - While stable == 1, the stuck counter increments, saturating at STUCK_CYCLES.
  - When stable == 0, the stuck counter clears.
  - STUCK[i] sets on the edge where the counter reaches STUCK_CYCLES and stays set.
- Stuck clear:
  - CLR_FAULT = 1 clears all STUCK bits on the next edge.
  - If a channel reaches threshold in the same cycle as CLR_FAULT, or its counter is already saturated, set wins. The bit stays 1 while the condition persists.
- Stuck does not modify S. Stopping trains on a fault is decided elsewhere.
- FAULT: registered OR of the next-state STUCK bits, so it updates in the same cycle as STUCK.
- Power-on with a sensor already active: S rises after the normal latency and RISE fires once. This is intended.
- Reset mid-debounce: all progress is discarded. After RESET deasserts, the full latency applies again.

Decomposition:
- Package train_pkg holds:
  - NUM_SENSORS = 5.
  - Sensor index constants SENS_A_ENTRY=0, SENS_B_ENTRY=1, SENS_B_EXIT=2, SENS_A_EXIT=3, SENS_SPARE=4.
  - Motor direction codes DIR_STOP = 2'b00 and DIR_FWD = 2'b01.
  - These are shared with the FSM and the motor driver.
- One sub-module, sensor_debounce_ch:
  - Contains the synchroniser, debounce counter, edge detect and stuck counter for one channel.
  - Top level instantiates it NUM_SENSORS times and builds FAULT.

Test Plan (bench uses SYNC_STAGES=2, DEB_CYCLES=4, STUCK_CYCLES=20):
1. Reset then RAW_S=5'b00001 held from edge 0 -> S1 rises at edge 6, RISE=5'b00001 for exactly one cycle, all other outputs 0.
2. RAW_S[1] pulses high for 3 cycles then low -> S2 stays 0, RISE stays 0. Repeat with 4 cycles -> S2 goes high 6 edges after the rising raw edge, then low 6 edges after the falling raw edge.
3. RAW_S[2] held high 30 cycles -> S3=1 at edge 6, STUCK=5'b00100 and FAULT=1 at edge 26. Drop RAW_S[2] and pulse CLR_FAULT -> STUCK=0 and FAULT=0 on the next edge.
4. CLR_FAULT held high while RAW_S[3] stays high past threshold -> STUCK[3] remains 1, because set wins.
5. RESET asserted mid-debounce (3 cycles into a raw change on RAW_S[4]) -> all outputs return to 0 immediately. After release, S5 rises exactly 6 edges later.
6. RAW_S=5'b11111 toggling every cycle for 50 cycles -> S1..S5 and RISE remain 0 throughout.
